cic_interpolator: RTL

CIC_INTERPOLATOR -- requirements
Module: cic_interpolator

---
 rtl/cic_interpolator.sv | 114 +++++++++++
 1 files changed

// File: rtl/cic_interpolator.sv
// CIC interpolator: low-rate combs, slot handoff, zero-stuffed high-rate integrators, gain-normalised saturating output.
// Latency: sample reaches out_data STAGES+1 ena ticks after its phase-0 injection; out_valid one cycle after each ena.
// Backpressure: single-entry slot; in_ready low while a sample waits for the next phase-0 tick.
module cic_interpolator #(
    parameter int BITLEN = 16,
    parameter int OSR    = 1024,
    parameter int STAGES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [BITLEN-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [BITLEN-1:0] out_data,
    output logic              out_valid,
    output logic              underrun
);

    localparam int LOG2R = $clog2(OSR);
    localparam int ACC   = BITLEN + STAGES * LOG2R;
    localparam int SHIFT = (STAGES - 1) * LOG2R;

    typedef logic signed [ACC-1:0] acc_t;

    localparam acc_t             SAT_HI  = (acc_t'(1) <<< (BITLEN - 1)) - acc_t'(1);
    localparam acc_t             SAT_LO  = -(acc_t'(1) <<< (BITLEN - 1));
    localparam logic [BITLEN-1:0] OUT_MAX = {1'b0, {(BITLEN-1){1'b1}}};
    localparam logic [BITLEN-1:0] OUT_MIN = {1'b1, {(BITLEN-1){1'b0}}};

    acc_t              dly     [STAGES];
    acc_t              comb_in [STAGES];
    acc_t              integ   [STAGES];
    acc_t              comb_out;
    acc_t              x_ext;
    acc_t              slot;
    acc_t              inj;
    acc_t              shifted;
    logic              slot_full;
    logic [LOG2R-1:0]  phase;
    logic              transfer;
    logic              tick0;
    logic [BITLEN-1:0] sat_out;

    assign in_ready = !slot_full;
    assign transfer = in_valid && !slot_full;
    assign tick0    = ena && (phase == '0);
    assign x_ext    = {{(ACC-BITLEN){in_data[BITLEN-1]}}, in_data};
    assign inj      = (tick0 && slot_full) ? slot : '0;

    // Comb chain is combinational off the delay registers, so the slot sees this sample's result.
    always_comb begin
        comb_out = x_ext;
        for (int k = 0; k < STAGES; k++) begin
            comb_in[k] = comb_out;
            comb_out   = comb_out - dly[k];
        end
    end

    always_comb begin
        shifted = integ[STAGES-1] >>> SHIFT;
        sat_out = shifted[BITLEN-1:0];
        if (shifted > SAT_HI) begin
            sat_out = OUT_MAX;
        end else if (shifted < SAT_LO) begin
            sat_out = OUT_MIN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < STAGES; k++) begin
                dly[k]   <= '0;
                integ[k] <= '0;
            end
            slot      <= '0;
            slot_full <= 1'b0;
            phase     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            if (transfer) begin
                for (int k = 0; k < STAGES; k++) begin
                    dly[k] <= comb_in[k];
                end
                slot <= comb_out;
            end

            // A transfer needs an empty slot and consumption needs a full one, so they never collide.
            if (transfer) begin
                slot_full <= 1'b1;
            end else if (tick0) begin
                slot_full <= 1'b0;
            end

            if (tick0 && !slot_full) begin
                underrun <= 1'b1;
            end

            out_valid <= ena;

            if (ena) begin
                phase    <= phase + LOG2R'(1);
                integ[0] <= integ[0] + inj;
                for (int k = 1; k < STAGES; k++) begin
                    integ[k] <= integ[k] + integ[k-1];
                end
                out_data <= sat_out;
            end
        end
    end

endmodule
